// File: rtl/twomux_arbiter_if.sv
// Handshake and data bundle between the two source streams, the arbiter and the mux stage.
// Ports: a_* / b_* valid-ready source streams, dina/dinb/sel toward the mux,
//        and dout_valid/dout_ready qualifying the mux output toward the consumer.
// slave modport: the arbiter side. master modport: the environment (sources and consumer).
interface twomux_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] dina;
  logic [WIDTH-1:0] dinb;
  logic             sel;
  logic             dout_valid;
  logic             dout_ready;

  modport slave (
    input  a_data, a_valid, b_data, b_valid, dout_ready,
    output a_ready, b_ready, dina, dinb, sel, dout_valid
  );

  modport master (
    output a_data, a_valid, b_data, b_valid, dout_ready,
    input  a_ready, b_ready, dina, dinb, sel, dout_valid
  );
endinterface

// File: rtl/twomux_arbiter.sv
// Purpose: buffers source streams A and B in small FIFOs and arbitrates them onto the 4-bit mux.
// Latency: word pushed into an empty FIFO at edge N (arbiter idle) is presented after edge N+1.
// Backpressure: a granted word holds sel/dina/dinb/dout_valid until dout_ready; x_ready = !full_x.
//
// Ports: clk, rst_n (async, active-low), bus (twomux_arbiter_if.slave):
//   a_data/a_valid/a_ready, b_data/b_valid/b_ready  source streams
//   dina/dinb  FIFO heads to the mux; sel 1 = pass dina (grant A), 0 = pass dinb (grant B)
//   dout_valid/dout_ready  mux output qualification toward the consumer
// Build option: define TWOMUX_ARB_PRIO_EN for fixed priority (A always wins when pending);
// the default build is round-robin.

// Small circular buffer; caller guarantees no push when full and no pop when empty.
module twomux_arbiter_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Pointers are AW bits wide, so the increment wraps modulo DEPTH (power of two).
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = cnt_q;
  assign full     = (cnt_q == CW'(DEPTH));
endmodule

module twomux_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  twomux_arbiter_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           sel_q, sel_d;
`ifndef TWOMUX_ARB_PRIO_EN
  logic           last_a_q, last_a_d;   // 1 = A was granted most recently
`endif

  logic [WIDTH-1:0] head_a, head_b;
  logic [CW-1:0]    cnt_a, cnt_b;
  logic             full_a, full_b;
  logic             push_a, push_b;
  logic             pop_a, pop_b;
  logic             arb, pend_a, pend_b, gnt_a, gnt_b;

  assign push_a = bus.a_valid && !full_a;
  assign push_b = bus.b_valid && !full_b;
  // A grant is only ever issued for a non-empty FIFO, so the pop never underflows.
  assign pop_a  = (state_q == GNT_A) && bus.dout_ready;
  assign pop_b  = (state_q == GNT_B) && bus.dout_ready;

  twomux_arbiter_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_a),
    .push_dat (bus.a_data),
    .pop      (pop_a),
    .head_dat (head_a),
    .count    (cnt_a),
    .full     (full_a)
  );

  twomux_arbiter_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_b),
    .push_dat (bus.b_data),
    .pop      (pop_b),
    .head_dat (head_b),
    .count    (cnt_b),
    .full     (full_b)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
`ifndef TWOMUX_ARB_PRIO_EN
    last_a_d = last_a_q;
`endif
    arb    = 1'b0;
    pend_a = 1'b0;
    pend_b = 1'b0;

    // Occupancy is judged from the registered counts: same-edge pushes are
    // invisible, and the granted source is judged post-pop (count > 1).
    case (state_q)
      IDLE: begin
        arb    = 1'b1;
        pend_a = (cnt_a != '0);
        pend_b = (cnt_b != '0);
      end
      GNT_A: begin
        arb    = bus.dout_ready;
        pend_a = (cnt_a > CNT_ONE);
        pend_b = (cnt_b != '0);
      end
      GNT_B: begin
        arb    = bus.dout_ready;
        pend_a = (cnt_a != '0);
        pend_b = (cnt_b > CNT_ONE);
      end
      default: begin
        arb = 1'b1;
      end
    endcase

`ifdef TWOMUX_ARB_PRIO_EN
    gnt_a = pend_a;
`else
    // On contention hand the grant to whichever source did not win last time.
    gnt_a = pend_a && (!pend_b || !last_a_q);
`endif
    gnt_b = pend_b && !gnt_a;

    if (arb) begin
      if (gnt_a) begin
        state_d = GNT_A;
        sel_d   = 1'b1;
      end else if (gnt_b) begin
        state_d = GNT_B;
        sel_d   = 1'b0;
      end else begin
        state_d = IDLE;   // sel deliberately keeps its last value
      end
`ifndef TWOMUX_ARB_PRIO_EN
      if (gnt_a || gnt_b) begin
        last_a_d = gnt_a;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
`ifndef TWOMUX_ARB_PRIO_EN
      last_a_q <= 1'b0;   // pretend B won last so A is favoured first
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
`ifndef TWOMUX_ARB_PRIO_EN
      last_a_q <= last_a_d;
`endif
    end
  end

  assign bus.a_ready    = !full_a;
  assign bus.b_ready    = !full_b;
  assign bus.dina       = head_a;
  assign bus.dinb       = head_b;
  assign bus.sel        = sel_q;
  assign bus.dout_valid = (state_q != IDLE);
endmodule
